// File: rtl/mode3_fetch_scheduler_pkg.sv
// Shared PPU Mode-3 types: scheduler states, BG fetcher state encodings
// (also used by the BG fetcher) and the VRAM port owner.
package mode3_fetch_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_BG        = 3'd1,
      S_SPR_WAIT  = 3'd2,
      S_SPR_FETCH = 3'd3,
      S_WIN_FLUSH = 3'd4
   } sched_state_t;

   localparam logic [2:0] FSTATE_GET_TILE = 3'd0;
   localparam logic [2:0] FSTATE_GET_LOW  = 3'd1;
   localparam logic [2:0] FSTATE_GET_HIGH = 3'd2;
   localparam logic [2:0] FSTATE_SLEEP    = 3'd3;
   localparam logic [2:0] FSTATE_PUSH     = 3'd4;

   typedef enum logic {
      OWNER_BG  = 1'b0,
      OWNER_SPR = 1'b1
   } vram_owner_t;

endpackage

// File: rtl/ppu_vram_port_mux.sv
// Single VRAM read port mux. Zero-latency select between the BG and the
// sprite fetcher; the non-owner's request is simply dropped.
// Ports:
//   en_i            - scheduler active this dot (else request/address forced to 0)
//   owner_i         - which fetcher owns the port
//   bg_req_i/addr_i, spr_req_i/addr_i - fetcher requests
//   req_o/addr_o    - muxed request to VRAM
module ppu_vram_port_mux
   import mode3_fetch_scheduler_pkg::*;
(
   input  logic        en_i,
   input  vram_owner_t owner_i,
   input  logic        bg_req_i,
   input  logic [15:0] bg_addr_i,
   input  logic        spr_req_i,
   input  logic [15:0] spr_addr_i,
   output logic        req_o,
   output logic [15:0] addr_o
);

   always_comb begin
      req_o  = 1'b0;
      addr_o = 16'h0000;
      if (en_i) begin
         if (owner_i == OWNER_SPR) begin
            req_o  = spr_req_i;
            addr_o = spr_addr_i;
         end else begin
            req_o  = bg_req_i;
            addr_o = bg_addr_i;
         end
      end
   end

endmodule

// File: rtl/mode3_fetch_scheduler.sv
// PPU Mode-3 fetch scheduler. Each dot decides whether the BG/window fetcher
// or the sprite fetcher owns the VRAM read port and whether the pixel shifter
// may advance. Sprite hits pause BG fetch and shifting; a window trigger
// flushes the BG fetcher.
// Ports:
//   clk_i, reset_i (synchronous, active high)
//   dot_en_i, window_trigger_i, spr_hit_i, spr_hit_idx_i  - per-dot events
//   bg_fetch_state_i, bg_fifo_empty_i                       - BG fetcher status
//   bg_vram_req_i/addr_i, spr_vram_req_i/addr_i             - fetcher requests
//   spr_fetch_done_i                                        - sprite fetch complete
//   bg_fetch_en_o, bg_flush_o, spr_fetch_start_o, spr_fetch_idx_o, shift_en_o
//   vram_read_req_o, vram_addr_o, owner_spr_o
// Optional (macro PPU_SCHED_STATS_EN): mode3_stall_dots_o, spr_fetched_o.
module mode3_fetch_scheduler
   import mode3_fetch_scheduler_pkg::*;
#(
   parameter int unsigned SPR_FETCH_DOTS   = 6,
   parameter int unsigned WIN_FLUSH_DOTS   = 1,
   parameter int unsigned MAX_SPR_PER_LINE = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        dot_en_i,
   input  logic        window_trigger_i,
   input  logic        spr_hit_i,
   input  logic [3:0]  spr_hit_idx_i,
   input  logic [2:0]  bg_fetch_state_i,
   input  logic        bg_fifo_empty_i,
   input  logic        bg_vram_req_i,
   input  logic [15:0] bg_vram_addr_i,
   input  logic        spr_vram_req_i,
   input  logic [15:0] spr_vram_addr_i,
   input  logic        spr_fetch_done_i,
   output logic        bg_fetch_en_o,
   output logic        bg_flush_o,
   output logic        spr_fetch_start_o,
   output logic [3:0]  spr_fetch_idx_o,
   output logic        shift_en_o,
   output logic        vram_read_req_o,
   output logic [15:0] vram_addr_o,
   output logic        owner_spr_o
`ifdef PPU_SCHED_STATS_EN
   ,
   output logic [8:0]  mode3_stall_dots_o,
   output logic [3:0]  spr_fetched_o
`endif
);

   localparam int unsigned CntMax = (SPR_FETCH_DOTS > WIN_FLUSH_DOTS) ?
                                    SPR_FETCH_DOTS : WIN_FLUSH_DOTS;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] SprLast = CntW'(SPR_FETCH_DOTS - 1);
   localparam logic [CntW-1:0] WinLast = CntW'(WIN_FLUSH_DOTS - 1);
   localparam logic [3:0]      MaxSpr  = 4'(MAX_SPR_PER_LINE);

   sched_state_t    state_q, state_d;
   logic [CntW-1:0] dot_cnt_q, dot_cnt_d;
   logic [3:0]      spr_cnt_q, spr_cnt_d;
   logic [3:0]      idx_q, idx_d;
   logic            pend_q, pend_d;
   logic            start_q, start_d;
   logic            hit_ok;
   logic            active;
   vram_owner_t     owner;

   // Hits past the per-line cap are invisible to the scheduler.
   assign hit_ok = spr_hit_i && (spr_cnt_q < MaxSpr);
   assign active = dot_en_i && (state_q != S_IDLE);

   always_comb begin
      state_d       = state_q;
      dot_cnt_d     = dot_cnt_q;
      spr_cnt_d     = spr_cnt_q;
      idx_d         = idx_q;
      pend_d        = pend_q;
      start_d       = 1'b0;
      bg_fetch_en_o = 1'b0;
      bg_flush_o    = 1'b0;
      shift_en_o    = 1'b0;
      owner         = OWNER_BG;
      if (!dot_en_i) begin
         // Leaving Mode 3 abandons any in-flight fetch or pending flush.
         state_d   = S_IDLE;
         pend_d    = 1'b0;
         dot_cnt_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d   = S_BG;
               spr_cnt_d = 4'd0;
            end
            S_BG: begin
               bg_fetch_en_o = 1'b1;
               shift_en_o    = !bg_fifo_empty_i && !hit_ok;
               // Window start outranks a coincident hit; the hit is seen again after.
               if (window_trigger_i || pend_q) begin
                  state_d   = S_WIN_FLUSH;
                  pend_d    = 1'b0;
                  dot_cnt_d = '0;
               end else if (hit_ok) begin
                  state_d = S_SPR_WAIT;
                  idx_d   = spr_hit_idx_i;
               end
            end
            S_SPR_WAIT: begin
               bg_fetch_en_o = 1'b1;
               if (window_trigger_i) pend_d = 1'b1;
               // Let the BG fetcher finish its tile before stealing the port.
               if (bg_fetch_state_i == FSTATE_PUSH && !bg_fifo_empty_i) begin
                  state_d   = S_SPR_FETCH;
                  dot_cnt_d = '0;
                  start_d   = 1'b1;
               end
            end
            S_SPR_FETCH: begin
               owner = OWNER_SPR;
               if (window_trigger_i) pend_d = 1'b1;
               if (spr_fetch_done_i || dot_cnt_q == SprLast) begin
                  state_d   = S_BG;
                  spr_cnt_d = spr_cnt_q + 4'd1;
                  dot_cnt_d = '0;
               end else begin
                  dot_cnt_d = dot_cnt_q + 1'b1;
               end
            end
            S_WIN_FLUSH: begin
               bg_flush_o = 1'b1;
               if (dot_cnt_q == WinLast) begin
                  state_d   = S_BG;
                  dot_cnt_d = '0;
               end else begin
                  dot_cnt_d = dot_cnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         dot_cnt_q <= '0;
         spr_cnt_q <= 4'd0;
         idx_q     <= 4'd0;
         pend_q    <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dot_cnt_q <= dot_cnt_d;
         spr_cnt_q <= spr_cnt_d;
         idx_q     <= idx_d;
         pend_q    <= pend_d;
         start_q   <= start_d;
      end
   end

   // Start pulse lands in the first sprite-fetch dot, with the latched slot.
   assign spr_fetch_start_o = start_q && dot_en_i;
   assign spr_fetch_idx_o   = spr_fetch_start_o ? idx_q : 4'd0;
   assign owner_spr_o       = (owner == OWNER_SPR);

   ppu_vram_port_mux u_vram_mux (
      .en_i       (active),
      .owner_i    (owner),
      .bg_req_i   (bg_vram_req_i),
      .bg_addr_i  (bg_vram_addr_i),
      .spr_req_i  (spr_vram_req_i),
      .spr_addr_i (spr_vram_addr_i),
      .req_o      (vram_read_req_o),
      .addr_o     (vram_addr_o)
   );

`ifdef PPU_SCHED_STATS_EN
   logic [8:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == S_IDLE && state_d == S_BG) begin
         stall_d = 9'd0;
      end else if (dot_en_i && (state_q inside {S_SPR_WAIT, S_SPR_FETCH, S_WIN_FLUSH})
                   && stall_q != 9'h1FF) begin
         stall_d = stall_q + 9'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) stall_q <= 9'd0;
      else         stall_q <= stall_d;
   end

   assign mode3_stall_dots_o = stall_q;
   assign spr_fetched_o      = spr_cnt_q;
`endif

endmodule

// File: tb/tb_mode3_fetch_scheduler.sv
module tb_mode3_fetch_scheduler;
   import mode3_fetch_scheduler_pkg::*;

   localparam logic [15:0] BGA = 16'h1234;
   localparam logic [15:0] SPA = 16'h8ABC;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, dot_en, window_trigger, spr_hit;
   logic [3:0]  spr_hit_idx;
   logic [2:0]  bg_fetch_state;
   logic        bg_fifo_empty, bg_vram_req, spr_vram_req, spr_fetch_done;
   logic [15:0] bg_vram_addr, spr_vram_addr;
   logic        bg_fetch_en, bg_flush, spr_fetch_start, shift_en, vram_read_req, owner_spr;
   logic [3:0]  spr_fetch_idx;
   logic [15:0] vram_addr;
`ifdef PPU_SCHED_STATS_EN
   logic [8:0]  mode3_stall_dots;
   logic [3:0]  spr_fetched;
`endif

   mode3_fetch_scheduler dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .dot_en_i         (dot_en),
      .window_trigger_i (window_trigger),
      .spr_hit_i        (spr_hit),
      .spr_hit_idx_i    (spr_hit_idx),
      .bg_fetch_state_i (bg_fetch_state),
      .bg_fifo_empty_i  (bg_fifo_empty),
      .bg_vram_req_i    (bg_vram_req),
      .bg_vram_addr_i   (bg_vram_addr),
      .spr_vram_req_i   (spr_vram_req),
      .spr_vram_addr_i  (spr_vram_addr),
      .spr_fetch_done_i (spr_fetch_done),
      .bg_fetch_en_o    (bg_fetch_en),
      .bg_flush_o       (bg_flush),
      .spr_fetch_start_o(spr_fetch_start),
      .spr_fetch_idx_o  (spr_fetch_idx),
      .shift_en_o       (shift_en),
      .vram_read_req_o  (vram_read_req),
      .vram_addr_o      (vram_addr),
      .owner_spr_o      (owner_spr)
`ifdef PPU_SCHED_STATS_EN
      ,
      .mode3_stall_dots_o(mode3_stall_dots),
      .spr_fetched_o     (spr_fetched)
`endif
   );

   typedef struct {
      logic [25:0] v;
      bit          cs;
      logic [8:0]  st;
      logic [3:0]  sc;
      int          ns;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   n_start = 0;

   // Expected output vector; address/request follow the owner when active.
   function automatic logic [25:0] mk(input logic fen, input logic fl, input logic st,
                                      input logic [3:0] idx, input logic sh,
                                      input logic own, input logic act);
      logic        req;
      logic [15:0] a;
      req = act ? (own ? spr_vram_req : bg_vram_req) : 1'b0;
      a   = act ? (own ? SPA : BGA) : 16'h0000;
      return {fen, fl, st, idx, sh, req, a, own};
   endfunction

   function automatic logic [25:0] e_idle();
      return mk(L, L, L, 4'd0, L, L, L);
   endfunction
   function automatic logic [25:0] e_bg(input logic sh);
      return mk(H, L, L, 4'd0, sh, L, H);
   endfunction
   function automatic logic [25:0] e_wait();
      return mk(H, L, L, 4'd0, L, L, H);
   endfunction
   function automatic logic [25:0] e_fetch(input logic st, input logic [3:0] idx);
      return mk(L, L, st, idx, L, H, H);
   endfunction
   function automatic logic [25:0] e_flush();
      return mk(L, H, L, 4'd0, L, L, H);
   endfunction

   // One dot: drive inputs, queue the expected outputs, advance to the next dot.
   task automatic dot(input logic den, input logic trig, input logic hit,
                      input logic [3:0] hidx, input logic [2:0] fst, input logic empty,
                      input logic done, input logic [25:0] ev, input string nm,
                      input bit cs = 1'b0, input int st = 0, input int sc = 0,
                      input int ns = -1);
      exp_t e;
      dot_en         = den;
      window_trigger = trig;
      spr_hit        = hit;
      spr_hit_idx    = hidx;
      bg_fetch_state = fst;
      bg_fifo_empty  = empty;
      spr_fetch_done = done;
      e.v    = ev;
      e.cs   = cs;
      e.st   = 9'(st);
      e.sc   = 4'(sc);
      e.ns   = ns;
      e.name = nm;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [25:0] act;
      act = {bg_fetch_en, bg_flush, spr_fetch_start, spr_fetch_idx, shift_en,
             vram_read_req, vram_addr, owner_spr};
      if (spr_fetch_start === 1'b1) n_start++;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_cmp++;
         if (act !== e.v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.v);
         end
         if (e.ns >= 0) begin
            n_cmp++;
            if (n_start != e.ns) begin
               n_bad++;
               $display("FAIL %s_starts: got %0d expected %0d", e.name, n_start, e.ns);
            end
         end
`ifdef PPU_SCHED_STATS_EN
         if (e.cs) begin
            n_cmp++;
            if ({mode3_stall_dots, spr_fetched} !== {e.st, e.sc}) begin
               n_bad++;
               $display("FAIL %s_stats: got stall=%0d cnt=%0d expected stall=%0d cnt=%0d",
                        e.name, mode3_stall_dots, spr_fetched, e.st, e.sc);
            end
         end
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; dot_en = L; window_trigger = L; spr_hit = L; spr_hit_idx = 4'd0;
      bg_fetch_state = 3'd0; bg_fifo_empty = H; spr_fetch_done = L;
      bg_vram_req = H; bg_vram_addr = BGA; spr_vram_req = H; spr_vram_addr = SPA;
      @(posedge clk);
      #1;
      dot(L, L, L, 4'd0, 3'd0, H, L, e_idle(), "reset", 1'b1, 0, 0, 0);
      reset = 1'b0;

      // 1: plain line, no sprites
      dot(H, L, L, 4'd0, 3'd0, H, L, e_idle(), "t1_idle");
      for (int i = 1; i < 172; i++)
         dot(H, L, L, 4'd0, 3'd0, (i < 9), L, e_bg(i >= 9), "t1_bg");
      dot(L, L, L, 4'd0, 3'd0, L, L, e_idle(), "t1_off", 1'b1, 0, 0);

      // 2: hit idx 3 during GET_LOW, full 6-dot fetch
      dot(H, L, L, 4'd0, 3'd0, L, L, e_idle(), "t2_idle");
      dot(H, L, L, 4'd0, 3'd1, L, L, e_bg(H), "t2_bg");
      dot(H, L, H, 4'd3, 3'd1, L, L, e_bg(L), "t2_hit");
      dot(H, L, H, 4'd3, 3'd2, L, L, e_wait(), "t2_wait");
      dot(H, L, H, 4'd3, FSTATE_PUSH, L, L, e_wait(), "t2_wait_push");
      dot(H, L, H, 4'd3, 3'd0, L, L, e_fetch(H, 4'd3), "t2_fetch0", 1'b0, 0, 0, 1);
      for (int k = 1; k < 6; k++)
         dot(H, L, H, 4'd3, 3'd0, L, L, e_fetch(L, 4'd0), "t2_fetch");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_bg(H), "t2_resume", 1'b1, 8, 1);

      // 3: early done at fetch dot 2; sprite request dropped low
      spr_vram_req = L;
      dot(H, L, H, 4'd7, 3'd0, L, L, e_bg(L), "t3_hit");
      dot(H, L, H, 4'd7, FSTATE_PUSH, L, L, e_wait(), "t3_wait");
      dot(H, L, H, 4'd7, 3'd0, L, L, e_fetch(H, 4'd7), "t3_fetch0");
      dot(H, L, H, 4'd7, 3'd0, L, L, e_fetch(L, 4'd0), "t3_fetch1");
      dot(H, L, H, 4'd7, 3'd0, L, H, e_fetch(L, 4'd0), "t3_done");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_bg(H), "t3_resume", 1'b1, 12, 2, 2);
      spr_vram_req = H;

      // 4: window + hit in one dot; then window during fetch
      dot(H, H, H, 4'd5, 3'd0, L, L, e_bg(L), "t4_trig_hit");
      dot(H, L, H, 4'd5, 3'd0, L, L, e_flush(), "t4_flush");
      dot(H, L, H, 4'd5, 3'd0, L, L, e_bg(L), "t4_rehit");
      dot(H, L, H, 4'd5, FSTATE_PUSH, L, L, e_wait(), "t4_wait");
      dot(H, H, H, 4'd5, 3'd0, L, L, e_fetch(H, 4'd5), "t4_fetch_trig");
      for (int k = 1; k < 6; k++)
         dot(H, L, L, 4'd0, 3'd0, L, L, e_fetch(L, 4'd0), "t4_fetch");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_bg(H), "t4_back");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_flush(), "t4_pend_flush");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_bg(H), "t4_bg", 1'b1, 21, 3, 3);

      // 5: twelve back-to-back hits; only ten are fetched
      dot(L, L, L, 4'd0, 3'd0, L, L, e_idle(), "t5_off");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_idle(), "t5_idle");
      for (int i = 0; i < 12; i++) begin
         if (i < 10) begin
            dot(H, L, H, 4'(i), 3'd0, L, L, e_bg(L), "t5_hit");
            dot(H, L, H, 4'(i), FSTATE_PUSH, L, L, e_wait(), "t5_wait");
            for (int k = 0; k < 6; k++)
               dot(H, L, H, 4'(i), 3'd0, L, L,
                   e_fetch(k == 0, (k == 0) ? 4'(i) : 4'd0), "t5_fetch");
         end else begin
            dot(H, L, H, 4'(i), 3'd0, L, L, e_bg(H), "t5_cap",
                (i == 11), 70, 10, (i == 11) ? 13 : -1);
         end
      end

      // 6: dot_en drops at fetch dot 3 (pending flush discarded)
      dot(L, L, L, 4'd0, 3'd0, L, L, e_idle(), "t6_off");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_idle(), "t6_idle");
      dot(H, L, H, 4'd2, 3'd0, L, L, e_bg(L), "t6_hit");
      dot(H, L, H, 4'd2, FSTATE_PUSH, L, L, e_wait(), "t6_wait");
      dot(H, L, H, 4'd2, 3'd0, L, L, e_fetch(H, 4'd2), "t6_fetch0");
      dot(H, H, H, 4'd2, 3'd0, L, L, e_fetch(L, 4'd0), "t6_fetch1_trig");
      dot(H, L, H, 4'd2, 3'd0, L, L, e_fetch(L, 4'd0), "t6_fetch2");
      dot(L, L, H, 4'd2, 3'd0, L, L, e_idle(), "t6_drop");
      dot(L, L, L, 4'd0, 3'd0, L, L, e_idle(), "t6_idle_after");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_idle(), "t6_reenter");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_bg(H), "t6_no_flush");

      // 7: reset while waiting for the BG tile
      dot(H, L, H, 4'd9, 3'd0, L, L, e_bg(L), "t7_hit");
      reset = 1'b1;
      dot(H, L, H, 4'd9, 3'd0, L, L, e_wait(), "t7_wait_rst");
      reset = 1'b0;
      dot(H, L, L, 4'd0, FSTATE_PUSH, L, L, e_idle(), "t7_after_rst");
      dot(H, L, L, 4'd0, 3'd0, L, L, e_bg(H), "t7_bg", 1'b1, 0, 0, 14);

      repeat (3) @(posedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
